param_register_file: RTL and testbench

//  Parametrised multi-read-port register file for the TPU control/datapath.

---
 rtl/param_register_file.sv | 123 ++++++++++++
 tb/tb_param_register_file.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : param_register_file
//  Purpose  : Parametrised multi-read-port register file with write-to-read
//             bypass, optional hardwired zero register and a per-register
//             busy scoreboard. Reads/reserves come from the decoder, writes
//             come from the result writeback stage.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             rd_en/rd_addr   - per-port read request (NUM_RD packed ports)
//             rd_data/rd_busy - registered per-port read data and busy flag
//             wr_en/wr_addr/wr_data - writeback port (clears busy)
//             rsv_en/rsv_addr - reserve request (sets busy)
//             rsv_stall       - combinational: reserve target still busy
//  Revision : 1.0 - initial release
// ============================================================================
module param_register_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_stall
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;

    logic [DATA_W-1:0] r_rd_data [NUM_RD];
    logic [NUM_RD-1:0] r_rd_busy;
    logic [ADDR_W-1:0] w_rd_addr [NUM_RD];

    logic w_wr_zero;
    logic w_rsv_zero;
    logic w_wr_ok;
    logic w_rsv_ok;

    // Address 0 is dropped entirely when it is the hardwired zero register.
    assign w_wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_rsv_zero = (ZERO_REG != 0) && (rsv_addr == '0);
    assign w_wr_ok    = wr_en && !w_wr_zero;

    // A same-cycle write to the reserved register retires the old producer,
    // so the new reserve may proceed without stalling.
    assign rsv_stall = rsv_en && !w_rsv_zero && r_busy[rsv_addr]
                       && !(w_wr_ok && (wr_addr == rsv_addr));
    assign w_rsv_ok  = rsv_en && !w_rsv_zero && !rsv_stall;

    // Post-update busy vector: reserve wins over write so the new producer
    // owns the register after a same-cycle write + reserve.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_ok) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_rsv_ok) begin
            w_busy_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_mem[wr_addr] <= wr_data;
            end
            r_busy <= w_busy_nxt;
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_port
            assign w_rd_addr[p]                  = rd_addr[p*ADDR_W +: ADDR_W];
            assign rd_data[p*DATA_W +: DATA_W]   = r_rd_data[p];
            assign rd_busy[p]                    = r_rd_busy[p];
        end
    endgenerate

    // Registered read ports; disabled ports hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_RD; p++) begin
                r_rd_data[p] <= '0;
            end
            r_rd_busy <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (rd_en[p]) begin
                    if ((ZERO_REG != 0) && (w_rd_addr[p] == '0)) begin
                        r_rd_data[p] <= '0;
                        r_rd_busy[p] <= 1'b0;
                    end else begin
                        if (w_wr_ok && (wr_addr == w_rd_addr[p])) begin
                            r_rd_data[p] <= wr_data;
                        end else begin
                            r_rd_data[p] <= r_mem[w_rd_addr[p]];
                        end
                        r_rd_busy[p] <= w_busy_nxt[w_rd_addr[p]];
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_register_file
//  Purpose  : Directed self-checking bench for param_register_file. Three
//             instances: default parameters (u_a), ZERO_REG=1 (u_b) and
//             DATA_W=16/ADDR_W=5/NUM_RD=3 (u_c).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_register_file;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---- instance A: defaults ----
    logic [1:0]  a_rd_en = '0;
    logic [7:0]  a_rd_addr = '0;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_wr_en = 1'b0;
    logic [3:0]  a_wr_addr = '0;
    logic [31:0] a_wr_data = '0;
    logic        a_rsv_en = 1'b0;
    logic [3:0]  a_rsv_addr = '0;
    logic        a_rsv_stall;

    // ---- instance B: ZERO_REG=1 ----
    logic [1:0]  b_rd_en = '0;
    logic [7:0]  b_rd_addr = '0;
    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic        b_wr_en = 1'b0;
    logic [3:0]  b_wr_addr = '0;
    logic [31:0] b_wr_data = '0;
    logic        b_rsv_en = 1'b0;
    logic [3:0]  b_rsv_addr = '0;
    logic        b_rsv_stall;

    // ---- instance C: DATA_W=16, ADDR_W=5, NUM_RD=3 ----
    logic [2:0]  c_rd_en = '0;
    logic [14:0] c_rd_addr = '0;
    logic [47:0] c_rd_data;
    logic [2:0]  c_rd_busy;
    logic        c_wr_en = 1'b0;
    logic [4:0]  c_wr_addr = '0;
    logic [15:0] c_wr_data = '0;
    logic        c_rsv_en = 1'b0;
    logic [4:0]  c_rsv_addr = '0;
    logic        c_rsv_stall;

    param_register_file #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0)) u_a (
        .clk(clk), .rst(rst),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rsv_en(a_rsv_en), .rsv_addr(a_rsv_addr), .rsv_stall(a_rsv_stall)
    );

    param_register_file #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1)) u_b (
        .clk(clk), .rst(rst),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr), .rsv_stall(b_rsv_stall)
    );

    param_register_file #(.DATA_W(16), .ADDR_W(5), .NUM_RD(3), .ZERO_REG(0)) u_c (
        .clk(clk), .rst(rst),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .rsv_en(c_rsv_en), .rsv_addr(c_rsv_addr), .rsv_stall(c_rsv_stall)
    );

    // Inputs change just after the falling edge; outputs sampled at the
    // following falling edge, one rising edge later.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_all();
        a_rd_en = '0; a_wr_en = 1'b0; a_rsv_en = 1'b0;
        b_rd_en = '0; b_wr_en = 1'b0; b_rsv_en = 1'b0;
        c_rd_en = '0; c_wr_en = 1'b0; c_rsv_en = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if (a_rd_data !== 64'd0 || a_rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_state: rd_data=%h rd_busy=%b, expected 0/00", a_rd_data, a_rd_busy);
        end
        a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 32'hDEAD_BEEF;
        tick();
        idle_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a_rd_en = 2'b11; a_rd_addr = {4'd3, 4'd3};
        tick();
        idle_all();
        n_tests++;
        if (a_rd_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_r3_data: got %h expected 0", a_rd_data);
        end
        n_tests++;
        if (a_rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_r3_busy: got %b expected 00", a_rd_busy);
        end
    endtask

    task automatic test_basic();
        a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 32'h1234_5678;
        tick();
        idle_all();
        a_rd_en = 2'b11; a_rd_addr = {4'd6, 4'd5};
        tick();
        idle_all();
        n_tests++;
        if (a_rd_data[31:0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL basic_port0: got %h expected 12345678", a_rd_data[31:0]);
        end
        n_tests++;
        if (a_rd_data[63:32] !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_port1: got %h expected 0", a_rd_data[63:32]);
        end
        // Disabled ports must hold even when addresses and contents change.
        a_rd_addr = {4'd5, 4'd6};
        a_wr_en = 1'b1; a_wr_addr = 4'd6; a_wr_data = 32'h0000_0099;
        tick();
        idle_all();
        n_tests++;
        if (a_rd_data !== {32'h0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL basic_hold: got %h expected 0000000012345678", a_rd_data);
        end
    endtask

    task automatic test_bypass();
        a_wr_en = 1'b1; a_wr_addr = 4'd7; a_wr_data = 32'hA5A5_A5A5;
        a_rd_en = 2'b10; a_rd_addr = {4'd7, 4'd0};
        tick();
        idle_all();
        n_tests++;
        if (a_rd_data[63:32] !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL bypass_port1: got %h expected a5a5a5a5", a_rd_data[63:32]);
        end
        n_tests++;
        if (a_rd_data[31:0] !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL bypass_port0_hold: got %h expected 12345678", a_rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        a_rsv_en = 1'b1; a_rsv_addr = 4'd2;
        #1;
        n_tests++;
        if (a_rsv_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_first_rsv_stall: got %b expected 0", a_rsv_stall);
        end
        tick();
        idle_all();
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd2};
        tick();
        idle_all();
        n_tests++;
        if (a_rd_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_busy_set: got %b expected 1", a_rd_busy[0]);
        end
        a_rsv_en = 1'b1; a_rsv_addr = 4'd2;
        #1;
        n_tests++;
        if (a_rsv_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_stall: got %b expected 1", a_rsv_stall);
        end
        tick();
        idle_all();
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd2};
        tick();
        idle_all();
        n_tests++;
        if (a_rd_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_busy_after_stall: got %b expected 1", a_rd_busy[0]);
        end
        a_wr_en = 1'b1; a_wr_addr = 4'd2; a_wr_data = 32'h42;
        a_rsv_en = 1'b1; a_rsv_addr = 4'd2;
        #1;
        n_tests++;
        if (a_rsv_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_wr_rsv_stall: got %b expected 0", a_rsv_stall);
        end
        tick();
        idle_all();
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd2};
        tick();
        idle_all();
        n_tests++;
        if (a_rd_data[31:0] !== 32'h42 || a_rd_busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_wr_rsv_result: data=%h busy=%b expected 00000042/1", a_rd_data[31:0], a_rd_busy[0]);
        end
        // Plain write clears busy; same-cycle read sees the post-update flag.
        a_wr_en = 1'b1; a_wr_addr = 4'd2; a_wr_data = 32'h43;
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd2};
        tick();
        idle_all();
        n_tests++;
        if (a_rd_data[31:0] !== 32'h43 || a_rd_busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_wr_clear: data=%h busy=%b expected 00000043/0", a_rd_data[31:0], a_rd_busy[0]);
        end
    endtask

    task automatic test_zero_reg();
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 32'hFFFF_FFFF;
        b_rsv_en = 1'b1; b_rsv_addr = 4'd0;
        b_rd_en = 2'b10; b_rd_addr = {4'd0, 4'd0};
        #1;
        n_tests++;
        if (b_rsv_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_rsv_stall: got %b expected 0", b_rsv_stall);
        end
        tick();
        idle_all();
        n_tests++;
        if (b_rd_data[63:32] !== 32'h0 || b_rd_busy[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_bypass: data=%h busy=%b expected 0/0", b_rd_data[63:32], b_rd_busy[1]);
        end
        b_rsv_en = 1'b1; b_rsv_addr = 4'd0;
        #1;
        n_tests++;
        if (b_rsv_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_rsv_stall_again: got %b expected 0", b_rsv_stall);
        end
        tick();
        idle_all();
        b_rd_en = 2'b11; b_rd_addr = {4'd0, 4'd0};
        tick();
        idle_all();
        n_tests++;
        if (b_rd_data !== 64'd0 || b_rd_busy !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_read: data=%h busy=%b expected 0/00", b_rd_data, b_rd_busy);
        end
        // Without ZERO_REG, register 0 is ordinary storage.
        a_wr_en = 1'b1; a_wr_addr = 4'd0; a_wr_data = 32'h0000_0011;
        tick();
        idle_all();
        a_rd_en = 2'b01; a_rd_addr = {4'd0, 4'd0};
        tick();
        idle_all();
        n_tests++;
        if (a_rd_data[31:0] !== 32'h11) begin
            n_fail++;
            $display("FAIL nonzero_r0: got %h expected 00000011", a_rd_data[31:0]);
        end
    endtask

    task automatic test_params();
        for (int i = 0; i < 32; i++) begin
            c_wr_en = 1'b1; c_wr_addr = i[4:0]; c_wr_data = 16'(i * 3);
            tick();
        end
        idle_all();
        c_rd_en = 3'b111; c_rd_addr = {5'd16, 5'd0, 5'd31};
        tick();
        idle_all();
        n_tests++;
        if (c_rd_data[15:0] !== 16'd93) begin
            n_fail++;
            $display("FAIL params_port0: got %0d expected 93", c_rd_data[15:0]);
        end
        n_tests++;
        if (c_rd_data[31:16] !== 16'd0) begin
            n_fail++;
            $display("FAIL params_port1: got %0d expected 0", c_rd_data[31:16]);
        end
        n_tests++;
        if (c_rd_data[47:32] !== 16'd48 || c_rd_busy !== 3'b000) begin
            n_fail++;
            $display("FAIL params_port2: data=%0d busy=%b expected 48/000", c_rd_data[47:32], c_rd_busy);
        end
    endtask

    task automatic test_back_to_back();
        a_wr_en = 1'b1; a_wr_addr = 4'd8; a_wr_data = 32'h80;
        a_rd_en = 2'b11; a_rd_addr = {4'd8, 4'd8};
        tick();
        a_wr_data = 32'h81;
        a_rd_en = 2'b01;
        tick();
        idle_all();
        n_tests++;
        if (a_rd_data !== {32'h80, 32'h81}) begin
            n_fail++;
            $display("FAIL b2b_write_read: got %h expected 0000008000000081", a_rd_data);
        end
    endtask

    initial begin
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_basic();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        test_params();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
